// File: rtl/i8080_fetch_unit_if.sv
// Bus bundle between the 8080 fetch unit, the unified memory read port and decode.
// master = fetch unit side, slave = memory/decode/control side.
interface i8080_fetch_unit_if;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] mem_raddr;
    logic [23:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_opcode;
    logic [15:0] instr_imm16;
    logic [1:0]  instr_len;
    logic [15:0] instr_pc;
    logic        halted;

    modport master (
        input  redirect,
        input  redirect_pc,
        output mem_raddr,
        input  mem_rdata,
        output instr_valid,
        input  instr_ready,
        output instr_opcode,
        output instr_imm16,
        output instr_len,
        output instr_pc,
        output halted
    );

    modport slave (
        output redirect,
        output redirect_pc,
        input  mem_raddr,
        output mem_rdata,
        input  instr_valid,
        output instr_ready,
        input  instr_opcode,
        input  instr_imm16,
        input  instr_len,
        input  instr_pc,
        input  halted
    );
endinterface

// File: rtl/i8080_fetch_unit.sv
// 8080 instruction fetch stage: issues a 3-byte window read, decodes length,
// presents one instruction over valid/ready and advances the PC; handles redirect and HLT.
module i8080_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned RD_LAT   = 2
) (
    input  logic               clk,
    input  logic               reset,
    i8080_fetch_unit_if.master bus
);

    localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [7:0]  OP_HLT = 8'h76;

    typedef enum logic [1:0] {
        S_ISSUE,
        S_WAIT,
        S_PRESENT,
        S_HALTED
    } state_t;

    state_t             state, state_nxt;
    logic [15:0]        pc, pc_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               valid, valid_nxt;
    logic               halted, halted_nxt;
    logic [7:0]         opcode, opcode_nxt;
    logic [15:0]        imm16, imm16_nxt;
    logic [1:0]         len, len_nxt;
    logic [15:0]        ipc, ipc_nxt;

    // Opcode -> instruction length (1..3).
    function automatic logic [1:0] decode_len(input logic [7:0] op);
        logic [1:0] l;
        l = 2'd1;
        casez (op)
            8'b00??_0001,            // LXI
            8'b001?_?010,            // SHLD/LHLD/STA/LDA
            8'b11??_?010,            // Jcc
            8'b1100_?011,            // JMP (+ alias)
            8'b11??_?100,            // Ccc
            8'b11??_1101:            // CALL (+ aliases)
                l = 2'd3;
            8'b00??_?110,            // MVI
            8'b11??_?110,            // ALU immediate
            8'b1101_?011:            // OUT/IN
                l = 2'd2;
            default:
                l = 2'd1;
        endcase
        return l;
    endfunction

    // State and datapath registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_ISSUE;
            pc     <= RESET_PC;
            cnt    <= '0;
            valid  <= 1'b0;
            halted <= 1'b0;
            opcode <= '0;
            imm16  <= '0;
            len    <= '0;
            ipc    <= RESET_PC;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            cnt    <= cnt_nxt;
            valid  <= valid_nxt;
            halted <= halted_nxt;
            opcode <= opcode_nxt;
            imm16  <= imm16_nxt;
            len    <= len_nxt;
            ipc    <= ipc_nxt;
        end
    end

    // Next-state and next-register values.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        cnt_nxt    = cnt;
        valid_nxt  = valid;
        halted_nxt = halted;
        opcode_nxt = opcode;
        imm16_nxt  = imm16;
        len_nxt    = len;
        ipc_nxt    = ipc;

        unique case (state)
            S_ISSUE: begin
                cnt_nxt   = CNT_W'(RD_LAT - 1);
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    opcode_nxt = bus.mem_rdata[23:16];
                    imm16_nxt  = {bus.mem_rdata[7:0], bus.mem_rdata[15:8]};
                    len_nxt    = decode_len(bus.mem_rdata[23:16]);
                    ipc_nxt    = pc;
                    valid_nxt  = 1'b1;
                    state_nxt  = S_PRESENT;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_PRESENT: begin
                if (valid && bus.instr_ready) begin
                    pc_nxt    = ipc + 16'(len);
                    valid_nxt = 1'b0;
                    if (opcode == OP_HLT) begin
                        halted_nxt = 1'b1;
                        state_nxt  = S_HALTED;
                    end else begin
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_HALTED: begin
                valid_nxt = 1'b0;
            end
            default: begin
                state_nxt = S_ISSUE;
            end
        endcase

        // Redirect discards any in-flight or presented instruction and leaves HALTED.
        if (bus.redirect) begin
            pc_nxt     = bus.redirect_pc;
            state_nxt  = S_ISSUE;
            valid_nxt  = 1'b0;
            halted_nxt = 1'b0;
        end
    end

    assign bus.mem_raddr    = pc;
    assign bus.instr_valid  = valid;
    assign bus.instr_opcode = opcode;
    assign bus.instr_imm16  = imm16;
    assign bus.instr_len    = len;
    assign bus.instr_pc     = ipc;
    assign bus.halted       = halted;

endmodule

// File: tb/tb_i8080_fetch_unit.sv
// Self-checking bench for i8080_fetch_unit: directed scenarios plus a randomized run
// against a transaction-level model of PC flow, instruction timing and length decode.
module tb_i8080_fetch_unit;

    localparam int unsigned RD_LAT   = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    i8080_fetch_unit_if bus ();

    i8080_fetch_unit #(
        .RESET_PC (RESET_PC),
        .RD_LAT   (RD_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Byte-addressed memory with an RD_LAT-deep read pipeline returning a 3-byte window.
    logic [7:0]  mem [0:65535];
    logic [23:0] pipe [RD_LAT];

    function automatic logic [23:0] window(input logic [15:0] a);
        return {mem[a], mem[16'(a + 16'd1)], mem[16'(a + 16'd2)]};
    endfunction

    always @(posedge clk) begin
        pipe[0] <= window(bus.mem_raddr);
        for (int i = 1; i < int'(RD_LAT); i++) pipe[i] <= pipe[i-1];
    end
    assign bus.mem_rdata = pipe[RD_LAT-1];

    // Length tables taken straight from the opcode lists.
    localparam logic [7:0] L3 [30] = '{
        8'h01, 8'h11, 8'h21, 8'h31, 8'h22, 8'h2A, 8'h32, 8'h3A,
        8'hC2, 8'hCA, 8'hD2, 8'hDA, 8'hE2, 8'hEA, 8'hF2, 8'hFA,
        8'hC3, 8'hCB,
        8'hC4, 8'hCC, 8'hD4, 8'hDC, 8'hE4, 8'hEC, 8'hF4, 8'hFC,
        8'hCD, 8'hDD, 8'hED, 8'hFD};
    localparam logic [7:0] L2 [18] = '{
        8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
        8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
        8'hD3, 8'hDB};

    function automatic logic [1:0] exp_len(input logic [7:0] op);
        for (int i = 0; i < 30; i++) if (L3[i] == op) return 2'd3;
        for (int i = 0; i < 18; i++) if (L2[i] == op) return 2'd2;
        return 2'd1;
    endfunction

    function automatic logic [15:0] exp_imm(input logic [15:0] a);
        return {mem[16'(a + 16'd2)], mem[16'(a + 16'd1)]};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.redirect = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.instr_valid && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) mem[i] = 8'($urandom);
        reset = 1'b1;
        tick();
        tick();
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.instr_valid); end
        checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0b exp=0", bus.halted); end
        checks++; if (bus.mem_raddr !== RESET_PC) begin failures++; $display("FAIL reset_raddr got=%h exp=%h", bus.mem_raddr, RESET_PC); end
        checks++; if (bus.instr_opcode !== 8'h00) begin failures++; $display("FAIL reset_opcode got=%h exp=00", bus.instr_opcode); end
        checks++; if (bus.instr_imm16 !== 16'h0000) begin failures++; $display("FAIL reset_imm got=%h exp=0000", bus.instr_imm16); end
        checks++; if (bus.instr_len !== 2'd0) begin failures++; $display("FAIL reset_len got=%0d exp=0", bus.instr_len); end
        checks++; if (bus.instr_pc !== RESET_PC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", bus.instr_pc, RESET_PC); end
        reset = 1'b0;
    endtask

    task automatic test_first_fetch();
        int n;
        mem[0] = 8'hC3; mem[1] = 8'h34; mem[2] = 8'h12;
        bus.instr_ready = 1'b1;
        do_reset();
        wait_valid(n);
        checks++; if (n !== 3) begin failures++; $display("FAIL first_latency got=%0d exp=3", n); end
        checks++; if (bus.instr_opcode !== 8'hC3) begin failures++; $display("FAIL first_opcode got=%h exp=c3", bus.instr_opcode); end
        checks++; if (bus.instr_imm16 !== 16'h1234) begin failures++; $display("FAIL first_imm got=%h exp=1234", bus.instr_imm16); end
        checks++; if (bus.instr_len !== 2'd3) begin failures++; $display("FAIL first_len got=%0d exp=3", bus.instr_len); end
        checks++; if (bus.instr_pc !== 16'h0000) begin failures++; $display("FAIL first_pc got=%h exp=0000", bus.instr_pc); end
        tick();
        checks++; if (bus.mem_raddr !== 16'h0003) begin failures++; $display("FAIL first_next_raddr got=%h exp=0003", bus.mem_raddr); end
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL first_valid_drop got=%0b exp=0", bus.instr_valid); end
    endtask

    task automatic test_short_instrs();
        int n;
        mem[0] = 8'h06; mem[1] = 8'h05; mem[2] = 8'h00;
        bus.instr_ready = 1'b1;
        do_reset();
        wait_valid(n);
        checks++; if (bus.instr_opcode !== 8'h06) begin failures++; $display("FAIL mvi_opcode got=%h exp=06", bus.instr_opcode); end
        checks++; if (bus.instr_len !== 2'd2) begin failures++; $display("FAIL mvi_len got=%0d exp=2", bus.instr_len); end
        checks++; if (bus.instr_imm16[7:0] !== 8'h05) begin failures++; $display("FAIL mvi_imm8 got=%h exp=05", bus.instr_imm16[7:0]); end
        checks++; if (bus.instr_pc !== 16'h0000) begin failures++; $display("FAIL mvi_pc got=%h exp=0000", bus.instr_pc); end
        tick();
        wait_valid(n);
        checks++; if (bus.instr_opcode !== 8'h00) begin failures++; $display("FAIL nop_opcode got=%h exp=00", bus.instr_opcode); end
        checks++; if (bus.instr_len !== 2'd1) begin failures++; $display("FAIL nop_len got=%0d exp=1", bus.instr_len); end
        checks++; if (bus.instr_pc !== 16'h0002) begin failures++; $display("FAIL nop_pc got=%h exp=0002", bus.instr_pc); end
    endtask

    task automatic test_stall();
        int n;
        logic [1:0] l;
        do mem[0] = 8'($urandom); while (mem[0] == 8'h76);
        mem[1] = 8'($urandom); mem[2] = 8'($urandom);
        l = exp_len(mem[0]);
        mem[l] = 8'h00;
        bus.instr_ready = 1'b0;
        do_reset();
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL stall_valid c%0d got=%0b exp=1", i, bus.instr_valid); end
            checks++; if (bus.instr_opcode !== mem[0] || bus.instr_imm16 !== exp_imm(16'h0000) || bus.instr_len !== l || bus.instr_pc !== 16'h0000)
                begin failures++; $display("FAIL stall_hold c%0d got=%h/%h/%0d/%h exp=%h/%h/%0d/0000", i, bus.instr_opcode, bus.instr_imm16, bus.instr_len, bus.instr_pc, mem[0], exp_imm(16'h0000), l); end
            checks++; if (bus.mem_raddr !== 16'h0000) begin failures++; $display("FAIL stall_raddr c%0d got=%h exp=0000", i, bus.mem_raddr); end
        end
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL stall_accept_valid got=%0b exp=0", bus.instr_valid); end
        checks++; if (bus.mem_raddr !== 16'(l)) begin failures++; $display("FAIL stall_accept_raddr got=%h exp=%h", bus.mem_raddr, 16'(l)); end
        wait_valid(n);
        checks++; if (n !== 3 || bus.instr_pc !== 16'(l)) begin failures++; $display("FAIL stall_one_accept got=n%0d pc%h exp=n3 pc%h", n, bus.instr_pc, 16'(l)); end
    endtask

    task automatic test_redirect_wait();
        int n;
        mem[16'h4000] = 8'h3E; mem[16'h4001] = 8'h5A;
        bus.instr_ready = 1'b0;
        do_reset();
        tick();
        bus.redirect = 1'b1; bus.redirect_pc = 16'h4000;
        tick();
        bus.redirect = 1'b0;
        checks++; if (bus.mem_raddr !== 16'h4000) begin failures++; $display("FAIL redir_raddr got=%h exp=4000", bus.mem_raddr); end
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL redir_valid got=%0b exp=0", bus.instr_valid); end
        wait_valid(n);
        checks++; if (n !== 3) begin failures++; $display("FAIL redir_latency got=%0d exp=3", n); end
        checks++; if (bus.instr_pc !== 16'h4000 || bus.instr_opcode !== 8'h3E) begin failures++; $display("FAIL redir_instr got=%h@%h exp=3e@4000", bus.instr_opcode, bus.instr_pc); end
    endtask

    task automatic test_halt();
        int n;
        mem[0] = 8'h76;
        mem[16'h0010] = 8'h00;
        bus.instr_ready = 1'b1;
        do_reset();
        wait_valid(n);
        checks++; if (bus.instr_opcode !== 8'h76 || bus.instr_len !== 2'd1) begin failures++; $display("FAIL hlt_decode got=%h len%0d exp=76 len1", bus.instr_opcode, bus.instr_len); end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (bus.halted !== 1'b1 || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL hlt_hold c%0d got=h%0b v%0b exp=h1 v0", i, bus.halted, bus.instr_valid); end
        end
        bus.redirect = 1'b1; bus.redirect_pc = 16'h0010;
        tick();
        bus.redirect = 1'b0;
        checks++; if (bus.halted !== 1'b0 || bus.mem_raddr !== 16'h0010) begin failures++; $display("FAIL hlt_resume got=h%0b a%h exp=h0 a0010", bus.halted, bus.mem_raddr); end
        wait_valid(n);
        checks++; if (bus.instr_pc !== 16'h0010 || n !== 3) begin failures++; $display("FAIL hlt_resume_pc got=%h n%0d exp=0010 n3", bus.instr_pc, n); end
    endtask

    task automatic test_redirect_accept();
        int n;
        mem[0] = 8'h76;
        bus.instr_ready = 1'b1;
        do_reset();
        wait_valid(n);
        bus.redirect = 1'b1; bus.redirect_pc = 16'h0200;
        tick();
        bus.redirect = 1'b0;
        checks++; if (bus.halted !== 1'b0 || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL redir_acc_state got=h%0b v%0b exp=h0 v0", bus.halted, bus.instr_valid); end
        checks++; if (bus.mem_raddr !== 16'h0200) begin failures++; $display("FAIL redir_acc_raddr got=%h exp=0200", bus.mem_raddr); end
    endtask

    task automatic test_wrap_and_reset();
        int n;
        mem[16'hFFFE] = 8'h21; mem[16'hFFFF] = 8'hAB; mem[0] = 8'hCD;
        bus.instr_ready = 1'b0;
        bus.redirect = 1'b1; bus.redirect_pc = 16'hFFFE;
        tick();
        bus.redirect = 1'b0;
        bus.instr_ready = 1'b1;
        wait_valid(n);
        checks++; if (bus.instr_len !== 2'd3 || bus.instr_pc !== 16'hFFFE || bus.instr_imm16 !== 16'hCDAB)
            begin failures++; $display("FAIL wrap_instr got=len%0d pc%h imm%h exp=len3 pcfffe immcdab", bus.instr_len, bus.instr_pc, bus.instr_imm16); end
        tick();
        checks++; if (bus.mem_raddr !== 16'h0001) begin failures++; $display("FAIL wrap_raddr got=%h exp=0001", bus.mem_raddr); end
        bus.instr_ready = 1'b0;
        wait_valid(n);
        reset = 1'b1;
        tick();
        checks++; if (bus.instr_valid !== 1'b0 || bus.mem_raddr !== RESET_PC || bus.halted !== 1'b0)
            begin failures++; $display("FAIL midreset got=v%0b a%h h%0b exp=v0 a%h h0", bus.instr_valid, bus.mem_raddr, bus.halted, RESET_PC); end
        reset = 1'b0;
    endtask

    // Random ready/redirect traffic against a transaction-level model.
    task automatic test_random();
        logic [15:0] e_pc;
        logic        e_halt;
        logic        e_valid;
        int          idx;
        int          bad;
        logic [7:0]  op;
        for (int i = 0; i < 65536; i++) mem[i] = ($urandom_range(0, 15) == 0) ? 8'h76 : 8'($urandom);
        bus.instr_ready = 1'b0;
        do_reset();
        e_pc = RESET_PC; e_halt = 1'b0; idx = 0;
        for (int c = 0; c < 3000; c++) begin
            e_valid = !e_halt && (idx >= int'(RD_LAT) + 1);
            op = mem[e_pc];
            bad = 0;
            if (bus.mem_raddr !== e_pc) bad |= 1;
            if (bus.instr_valid !== e_valid) bad |= 2;
            if (bus.halted !== e_halt) bad |= 4;
            if (e_valid && (bus.instr_opcode !== op || bus.instr_len !== exp_len(op) ||
                            bus.instr_imm16 !== exp_imm(e_pc) || bus.instr_pc !== e_pc)) bad |= 8;
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL rand c%0d mask=%0d got=a%h v%0b h%0b op%h len%0d imm%h pc%h exp=a%h v%0b h%0b op%h len%0d imm%h",
                         c, bad, bus.mem_raddr, bus.instr_valid, bus.halted, bus.instr_opcode, bus.instr_len,
                         bus.instr_imm16, bus.instr_pc, e_pc, e_valid, e_halt, op, exp_len(op), exp_imm(e_pc));
            end
            bus.instr_ready = 1'($urandom_range(0, 1));
            bus.redirect    = ($urandom_range(0, e_halt ? 3 : 40) == 0);
            bus.redirect_pc = 16'($urandom);
            if (bus.redirect) begin
                e_pc = bus.redirect_pc; e_halt = 1'b0; idx = 0;
            end else if (e_valid && bus.instr_ready) begin
                e_pc = 16'(e_pc + 16'(exp_len(op)));
                idx = 0;
                if (op == 8'h76) e_halt = 1'b1;
            end else begin
                idx++;
            end
            tick();
        end
        bus.redirect = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        checks = 0;
        failures = 0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 16'h0000;
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        tick();
        test_reset();
        test_first_fetch();
        test_short_instrs();
        test_stall();
        test_redirect_wait();
        test_halt();
        test_redirect_accept();
        test_wrap_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
